// File: rtl/mips_pipe_pkg.sv
// Shared fetch-stage types and constants.
// FSM encoding, NOP word and default reset pc.
package mips_pipe_pkg;

  typedef enum logic {
    FETCH   = 1'b0,
    PRESENT = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] next_pc(
    input logic [31:0] pc
  );
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction memory request/response bundle.
// master = fetch unit, slave = memory.
interface if_fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );

endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: one outstanding request,
// redirect latching and a sticky ack watchdog.
module if_fetch_unit
  import mips_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          WDOG_MAX = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  if_fetch_unit_if.master        imem,
  input  logic                   stall_in,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_target,
  output logic [31:0]            out_Instruction_Data,
  output logic [31:0]            out_Add4_PC_4,
  output logic                   out_fetch_valid,
  output logic                   out_IF_Hold,
  output logic                   out_fetch_timeout
);

  localparam int CW = $clog2(WDOG_MAX + 1);
  localparam logic [CW-1:0] WMAX = CW'(WDOG_MAX);

  fetch_state_e  state, state_n;
  logic [31:0]   pc, pc_n;
  logic          pend, pend_n;
  logic [31:0]   tgt, tgt_n;
  logic [31:0]   data, data_n;
  logic [31:0]   add4, add4_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          tout, tout_n;
  logic          fresh;
  logic          ack_ok;

  // an ack right after reset belongs to the abandoned access
  assign ack_ok = imem.imem_ack & ~fresh;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    pend_n  = pend;
    tgt_n   = tgt;
    data_n  = data;
    add4_n  = add4;
    cnt_n   = cnt;
    tout_n  = tout;
    unique case (state)
      FETCH: begin
        if (ack_ok) begin
          cnt_n = '0;
          if (redirect_valid) begin
            pc_n   = redirect_target;
            pend_n = 1'b0;
          end else if (pend) begin
            pc_n   = tgt;
            pend_n = 1'b0;
          end else begin
            data_n  = imem.imem_rdata;
            add4_n  = next_pc(pc);
            state_n = PRESENT;
          end
        end else begin
          if (redirect_valid) begin
            pend_n = 1'b1;
            tgt_n  = redirect_target;
          end
          if (cnt != WMAX) cnt_n = cnt + 1'b1;
          if (cnt_n == WMAX) tout_n = 1'b1;
        end
      end
      PRESENT: begin
        cnt_n = '0;
        if (redirect_valid) begin
          pc_n    = redirect_target;
          state_n = FETCH;
        end else if (!stall_in) begin
          pc_n    = next_pc(pc);
          state_n = FETCH;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc    <= RESET_PC;
      pend  <= 1'b0;
      tgt   <= NOP;
      data  <= NOP;
      add4  <= '0;
      cnt   <= '0;
      tout  <= 1'b0;
      fresh <= 1'b1;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      pend  <= pend_n;
      tgt   <= tgt_n;
      data  <= data_n;
      add4  <= add4_n;
      cnt   <= cnt_n;
      tout  <= tout_n;
      fresh <= 1'b0;
    end
  end

  assign imem.imem_req      = (state == FETCH) & ~rst;
  assign imem.imem_addr     = pc;
  assign out_Instruction_Data = data;
  assign out_Add4_PC_4      = add4;
  assign out_fetch_valid    = (state == PRESENT);
  assign out_IF_Hold        = stall_in | ~out_fetch_valid;
  assign out_fetch_timeout  = tout;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: vector table, directed
// corner sequences and a randomized reference model.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_in = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic [31:0] out_Instruction_Data;
  logic [31:0] out_Add4_PC_4;
  logic        out_fetch_valid;
  logic        out_IF_Hold;
  logic        out_fetch_timeout;

  if_fetch_unit_if imem();

  always #5 clk = ~clk;

  if_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .WDOG_MAX(15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem(imem),
    .stall_in(stall_in),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .out_Instruction_Data(out_Instruction_Data),
    .out_Add4_PC_4(out_Add4_PC_4),
    .out_fetch_valid(out_fetch_valid),
    .out_IF_Hold(out_IF_Hold),
    .out_fetch_timeout(out_fetch_timeout)
  );

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] tgt;
    logic        ack;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] add4;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act,
                      input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic r,
                       input logic [31:0] t, input logic a);
    @(negedge clk);
    rst = 1'b0;
    stall_in = s;
    redirect_valid = r;
    redirect_target = t;
    imem.imem_ack = a;
    imem.imem_rdata = memw(imem.imem_addr);
    #1;
  endtask

  task automatic reset_seq();
    @(negedge clk);
    rst = 1'b1;
    stall_in = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    imem.imem_ack = 1'b0;
    #1;
    chk1("rst_req_now", imem.imem_req, 1'b0);
    @(negedge clk);
    #1;
    chk1("rst_req", imem.imem_req, 1'b0);
    chk("rst_data", out_Instruction_Data, 32'h0);
    chk("rst_add4", out_Add4_PC_4, 32'h0);
    chk1("rst_valid", out_fetch_valid, 1'b0);
    chk1("rst_tout", out_fetch_timeout, 1'b0);
    chk1("rst_hold", out_IF_Hold, 1'b1);
  endtask

  task automatic add(input logic s, input logic r,
                     input logic [31:0] t, input logic a,
                     input logic q, input logic [31:0] ad,
                     input logic v, input logic [31:0] a4);
    vec_t e;
    e.stall = s; e.rv = r; e.tgt = t; e.ack = a;
    e.req = q; e.addr = ad; e.valid = v; e.add4 = a4;
    tbl.push_back(e);
  endtask

  // reference model state for the random phase
  bit          m_fetch;
  bit          m_pend;
  bit          m_to;
  bit          m_fresh;
  logic [31:0] m_pc;
  logic [31:0] m_ptgt;
  int          m_wait;

  initial begin
    imem.imem_ack = 1'b0;
    imem.imem_rdata = 32'h0;

    //   s  rv tgt          ack req addr        v  add4
    add(0, 0, 32'h0,   1,  1, 32'h0,   0, 32'h0);
    add(0, 0, 32'h0,   1,  1, 32'h0,   0, 32'h0);
    add(0, 0, 32'h0,   0,  0, 32'h0,   1, 32'h4);
    add(0, 0, 32'h0,   1,  1, 32'h4,   0, 32'h0);
    add(0, 0, 32'h0,   0,  0, 32'h0,   1, 32'h8);
    add(0, 0, 32'h0,   1,  1, 32'h8,   0, 32'h0);
    for (int k = 0; k < 5; k++)
      add(1, 0, 32'h0, 0,  0, 32'h0,   1, 32'hC);
    add(0, 0, 32'h0,   0,  0, 32'h0,   1, 32'hC);
    add(0, 0, 32'h0,   1,  1, 32'hC,   0, 32'h0);
    add(0, 0, 32'h0,   0,  0, 32'h0,   1, 32'h10);
    for (int k = 0; k < 3; k++)
      add(0, 0, 32'h0, 0,  1, 32'h10,  0, 32'h0);
    add(0, 0, 32'h0,   1,  1, 32'h10,  0, 32'h0);
    add(0, 0, 32'h0,   0,  0, 32'h0,   1, 32'h14);
    add(0, 1, 32'h100, 0,  1, 32'h14,  0, 32'h0);
    add(0, 0, 32'h0,   1,  1, 32'h14,  0, 32'h0);
    add(0, 1, 32'h200, 0,  1, 32'h100, 0, 32'h0);
    add(0, 1, 32'h300, 0,  1, 32'h100, 0, 32'h0);
    add(0, 0, 32'h0,   1,  1, 32'h100, 0, 32'h0);
    add(0, 1, 32'h400, 1,  1, 32'h300, 0, 32'h0);
    add(0, 0, 32'h0,   1,  1, 32'h400, 0, 32'h0);
    add(1, 1, 32'h800, 0,  0, 32'h0,   1, 32'h404);
    add(0, 0, 32'h0,   0,  1, 32'h800, 0, 32'h0);
    add(0, 1, 32'h900, 0,  1, 32'h800, 0, 32'h0);
    add(0, 1, 32'hA00, 1,  1, 32'h800, 0, 32'h0);
    add(0, 0, 32'h0,   0,  1, 32'hA00, 0, 32'h0);

    reset_seq();
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].stall, tbl[i].rv, tbl[i].tgt, tbl[i].ack);
      chk1($sformatf("v%0d_req", i), imem.imem_req, tbl[i].req);
      if (tbl[i].req)
        chk($sformatf("v%0d_addr", i), imem.imem_addr, tbl[i].addr);
      chk1($sformatf("v%0d_valid", i), out_fetch_valid, tbl[i].valid);
      if (tbl[i].valid) begin
        chk($sformatf("v%0d_add4", i), out_Add4_PC_4, tbl[i].add4);
        chk($sformatf("v%0d_data", i), out_Instruction_Data,
            memw(tbl[i].add4 - 32'd4));
      end
      chk1($sformatf("v%0d_hold", i), out_IF_Hold,
           tbl[i].stall | ~tbl[i].valid);
      chk1($sformatf("v%0d_tout", i), out_fetch_timeout, 1'b0);
    end

    // present something, then reset over it
    drive(0, 0, 32'h0, 1);
    drive(1, 0, 32'h0, 0);
    chk("pre_rst_data", out_Instruction_Data, memw(32'hA00));
    reset_seq();

    // watchdog: 15 ack-less fetch cycles, sticky until reset
    for (int k = 0; k < 15; k++) begin
      drive(0, 0, 32'h0, 0);
      chk("wd_addr", imem.imem_addr, 32'h0);
      if (k == 14) chk1("wd_before", out_fetch_timeout, 1'b0);
    end
    drive(0, 0, 32'h0, 1);
    chk1("wd_set", out_fetch_timeout, 1'b1);
    drive(0, 0, 32'h0, 0);
    chk1("wd_after_ack", out_fetch_timeout, 1'b1);
    chk1("wd_present", out_fetch_valid, 1'b1);
    drive(0, 0, 32'h0, 0);
    chk1("wd_sticky", out_fetch_timeout, 1'b1);
    reset_seq();

    // pc+4 wraps through zero
    drive(0, 1, 32'hFFFF_FFFC, 0);
    drive(0, 0, 32'h0, 1);
    drive(0, 0, 32'h0, 1);
    chk("wrap_addr", imem.imem_addr, 32'hFFFF_FFFC);
    drive(0, 0, 32'h0, 0);
    chk("wrap_add4", out_Add4_PC_4, 32'h0);
    drive(0, 0, 32'h0, 0);
    chk("wrap_next", imem.imem_addr, 32'h0);
    chk1("wrap_req", imem.imem_req, 1'b1);

    // randomized run against the reference model
    reset_seq();
    m_fetch = 1; m_pc = 32'h0; m_pend = 0; m_ptgt = 32'h0;
    m_wait = 0; m_to = 0; m_fresh = 1;
    for (int c = 0; c < 3000; c++) begin
      logic s, r, a, rs;
      logic [31:0] t;
      @(negedge clk);
      rs = ($urandom_range(0, 299) == 0);
      rst = rs;
      s = ($urandom_range(0, 9) < 3);
      r = ($urandom_range(0, 9) == 0);
      t = $urandom & 32'hFFFF_FFFC;
      a = imem.imem_req && ($urandom_range(0, 9) < 6);
      stall_in = s;
      redirect_valid = r;
      redirect_target = t;
      imem.imem_ack = a;
      imem.imem_rdata = memw(imem.imem_addr);
      #1;
      if (rs) begin
        chk1("rnd_rst_req", imem.imem_req, 1'b0);
        m_fetch = 1; m_pc = 32'h0; m_pend = 0;
        m_wait = 0; m_to = 0; m_fresh = 1;
      end else begin
        chk1("rnd_req", imem.imem_req, m_fetch);
        if (m_fetch) chk("rnd_addr", imem.imem_addr, m_pc);
        chk1("rnd_valid", out_fetch_valid, !m_fetch);
        if (!m_fetch) begin
          chk("rnd_data", out_Instruction_Data, memw(m_pc));
          chk("rnd_add4", out_Add4_PC_4, m_pc + 32'd4);
        end
        chk1("rnd_hold", out_IF_Hold, s | m_fetch);
        chk1("rnd_tout", out_fetch_timeout, m_to);
        if (m_fetch) begin
          if (a && !m_fresh) begin
            m_wait = 0;
            if (r) begin
              m_pc = t; m_pend = 0;
            end else if (m_pend) begin
              m_pc = m_ptgt; m_pend = 0;
            end else begin
              m_fetch = 0;
            end
          end else begin
            if (r) begin
              m_pend = 1; m_ptgt = t;
            end
            m_wait++;
            if (m_wait >= 15) m_to = 1;
          end
        end else begin
          m_wait = 0;
          if (r) begin
            m_pc = t; m_fetch = 1;
          end else if (!s) begin
            m_pc = m_pc + 32'd4; m_fetch = 1;
          end
        end
        m_fresh = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter WDOG_MAX, default 15, the ack-wait cycle count that flags a timeout.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  clock; all state SHALL update on posedge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 imem_req  out  1  instruction memory request.
REQ-007 imem_addr  out  32  word address of the request, equal to pc.
REQ-008 imem_rdata  in  32  instruction word, valid when imem_ack=1.
REQ-009 imem_ack  in  1  one-cycle response strobe for the outstanding request.
REQ-010 stall_in  in  1  decode-side hold request: do not hand over the presented instruction.
REQ-011 redirect_valid  in  1  one-cycle strobe for a taken branch or jump.
REQ-012 redirect_target  in  32  new pc, sampled when redirect_valid=1.
REQ-013 out_Instruction_Data  out  32  registered instruction presented to the IF/ID register.
REQ-014 out_Add4_PC_4  out  32  registered address of the presented instruction plus 4.
REQ-015 out_fetch_valid  out  1  presented instruction is valid and not yet consumed.
REQ-016 out_IF_Hold  out  1  combinational stall_in | ~out_fetch_valid; the IF/ID register holds while this is 1.
REQ-017 out_fetch_timeout  out  1  sticky watchdog error flag.

Function
REQ-018 SHALL implement a two-state FSM: FETCH and PRESENT.
REQ-019 SHALL allow at most one outstanding memory request.
REQ-020 In FETCH: imem_req=1, and imem_addr=pc SHALL remain stable until imem_ack.
REQ-021 In FETCH, on imem_ack with no redirect pending or arriving:
- capture imem_rdata into out_Instruction_Data;
- set out_Add4_PC_4 = pc+4 (mod 2^32);
- set out_fetch_valid=1 from the next cycle;
- go to PRESENT.
REQ-022 In PRESENT: imem_req=0 and out_fetch_valid=1.
- Consumption happens on an edge with stall_in=0: pc<=pc+4, out_fetch_valid<=0, go to FETCH.
- stall_in=1 holds all outputs and state unchanged for any number of cycles.
REQ-023 A redirect in PRESENT SHALL take priority over consumption and stall: pc<=redirect_target, out_fetch_valid<=0, go to FETCH.
REQ-024 A redirect in FETCH without imem_ack SHALL latch the target and set a pending flag; the outstanding request continues unchanged.
REQ-025 A later redirect while one is pending SHALL overwrite the latched target (latest wins).
REQ-026 On imem_ack with a redirect pending or arriving in the same cycle:
- discard the response;
- set pc to the newest target (an arriving target beats a latched one);
- clear the pending flag;
- stay in FETCH, with imem_req high and the new address on the next cycle.
REQ-027 Minimum throughput SHALL be one instruction per 2 cycles with a zero-wait-state memory.
REQ-028 The watchdog counter SHALL count consecutive FETCH cycles without imem_ack, saturating at WDOG_MAX.
- It clears on imem_ack and on leaving FETCH.
- out_fetch_timeout sets when the count reaches WDOG_MAX and clears only on reset.
REQ-029 pc+4 SHALL wrap modulo 2^32 without error.

Reset
REQ-030 On rst=1 at a posedge, the block SHALL set:
- state=FETCH, pc=RESET_PC, redirect pending=0, watchdog=0;
- out_Instruction_Data=0, out_Add4_PC_4=0, out_fetch_valid=0, out_fetch_timeout=0.
REQ-031 Reset mid-request SHALL abandon the outstanding access; an imem_ack arriving in the first cycle after reset SHALL be ignored.
REQ-032 imem_req SHALL be 0 while rst=1.

Structure
REQ-033 FSM state encoding, NOP word (32'h0) and default RESET_PC SHALL live in shared package mips_pipe_pkg.
REQ-034 Single module; no sub-module required.

Verification
REQ-035 Reset with RESET_PC=0, then zero-wait memory returning ack each cycle: addresses 0,4,8 are requested, and out_Add4_PC_4 reads 4,8,12 on consecutive presents.
REQ-036 Ack delayed 3 cycles at pc=0x10: imem_addr holds 0x10 for 4 cycles, and out_fetch_valid rises the cycle after ack.
REQ-037 stall_in=1 for 5 cycles in PRESENT: outputs stay frozen, out_IF_Hold=1, and no new imem_req is issued.
REQ-038 Redirect to 0x100 during wait, then ack: the response is discarded, the next imem_addr is 0x100, and out_fetch_valid stays 0 throughout.
REQ-039 Redirects to 0x200 then 0x300 while pending, and again a redirect arriving with ack: the next imem_addr is 0x300, or the target arriving with the ack.
REQ-040 No ack for 15 cycles: out_fetch_timeout=1 and stays 1 after a later ack, until rst.
